escalonador_rr: RTL and testbench
=================================

# escalonador_rr

Round-robin context-switch engine that acts on the preemption request raised by the instruction counter. When a user process's quantum expires, it stores the process's resume address in a per-process PC table and picks the next ready process. It then drives the PC loader with that process's address. It also owns `idProc` and the PC-run enable that the counter samples, which closes the loop between preemption detection and process dispatch.

## Interface
- `NUM_PROC`, 8: table slots; slot 0 is the SO, slots 1..NUM_PROC-1 are user processes.
- `SO_PC`, 32'd0: reset value of `pc_tab[0]`, the SO entry address.
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `swap_SO`  in  1  preemption request from the counter; sampled at posedge.
- `ultimo_pc`  in  32  resume PC of the preempted process; valid when `swap_SO`=1.
- `finalizar`  in  1  the current user process terminates; its slot is released.
- `despachar`  in  1  SO requests dispatch of a user process; honoured only when `idProc`=0.
- `criar`  in  1  register a new process.
- `criar_id`  in  5  slot for `criar`.
- `criar_pc`  in  32  start PC for `criar`.
- `idProc`  out  5  id of the running process.
- `pc_carga`  out  32  PC to load into the program counter.
- `carrega_pc`  out  1  one-cycle load strobe for `pc_carga`.
- `pausa_PC`  out  1  1 = PC running and counter may count; 0 = PC held during a switch.
- `ocupado`  out  1  1 while not in EXEC.

## Operation
- Storage:
  - `pc_tab[NUM_PROC]` x 32.
  - `valid[NUM_PROC]`; `valid[0]` is always 1.
  - `rr_ptr` (5 bits) holds the last dispatched user id.
- FSM states are EXEC, SALVA, BUSCA and DESPACHA.
- EXEC (`pausa_PC`=1, `ocupado`=0). Requests are checked in this priority order:
  - `finalizar` and `idProc`!=0: clear `valid[idProc]`, go to BUSCA without saving.
  - `swap_SO` and `idProc`!=0: go to SALVA.
  - `despachar` and `idProc`=0: go to BUSCA.
  - `swap_SO` or `finalizar` while `idProc`=0 is ignored.
  - Leaving EXEC registers `pausa_PC`<=0.
- SALVA: `pc_tab[idProc]` <= `ultimo_pc`, then go to BUSCA.
- BUSCA: single-cycle combinational search.
  - Order: slots `rr_ptr`+1 .. NUM_PROC-1, then 1 .. `rr_ptr`. This includes the just-preempted process, which is selected last.
  - The first slot with `valid`=1 becomes `sel`. If no user slot is valid, `sel`=0.
  - Registered results: `idProc`<=`sel`, `pc_carga`<=`pc_tab[sel]`, `carrega_pc`<=1. `rr_ptr`<=`sel` only if `sel`!=0.
  - Next state is DESPACHA.
- DESPACHA: `carrega_pc`<=0, `pausa_PC`<=1, then go to EXEC.
- `criar` is accepted in any state.
  - If `criar_id` is in 1..NUM_PROC-1: `pc_tab[criar_id]`<=`criar_pc` and `valid`<=1.
  - `criar_id` = 0 or `criar_id` >= NUM_PROC is ignored.
  - `criar` wins over a same-cycle `finalizar` clear or SALVA write to the same slot.
  - BUSCA uses pre-edge `valid` and `pc_tab` values. A slot created in the BUSCA cycle is not eligible.
- PC arithmetic is 32-bit with no modification; `ultimo_pc` already points to the resume instruction.

## Timing
- Reset (`rst_n`=0 at posedge) sets:
  - state EXEC, `idProc`=0, `pc_carga`=0, `carrega_pc`=0, `pausa_PC`=1, `ocupado`=0.
  - `valid`=000..01, `pc_tab[0]`=`SO_PC`, `rr_ptr`=0.
  - Other `pc_tab` entries are don't-care.
- Reset mid-switch aborts the switch and produces no `carrega_pc`.
- Preemption accepted at edge N:
  - `pausa_PC`=0 after edge N.
  - Table write at edge N+1.
  - `idProc`, `pc_carga` and `carrega_pc`=1 after edge N+2.
  - `carrega_pc`=0 and `pausa_PC`=1 after edge N+3.
- `finalizar` or `despachar` at edge N: outputs update after edge N+1, and `pausa_PC` returns to 1 after edge N+2.
- `swap_SO`, `finalizar` and `despachar` outside EXEC are ignored; the counter holds `swap_SO` while `pausa_PC`=0.
- `idProc` changes only at the edge that raises `carrega_pc`.

## Test plan
- Reset, then `criar` id1 PC 0x100 and id2 PC 0x200, then `despachar` -> `idProc`=1, `pc_carga`=0x100, `carrega_pc` high one cycle, 2 cycles after the request.
- With id1 running, `swap_SO`=1 and `ultimo_pc`=0x10F -> `pausa_PC` low 3 cycles, `idProc`=2, `pc_carga`=0x200. The next preemption returns to id1 with `pc_carga`=0x10F.
- Only id1 valid and running, then `finalizar` -> `idProc`=0, `pc_carga`=`SO_PC`, `valid[1]`=0.
- With id3 running and slots 1, 3, 5 valid (`rr_ptr`=3), `swap_SO` -> `idProc`=5. Next `swap_SO` -> `idProc`=1 (wrap-around).
- `swap_SO`=1 while `idProc`=0 -> no state change, `pausa_PC` stays 1. `criar_id`=0 -> `pc_tab[0]` unchanged.
- Assert `rst_n`=0 in SALVA -> next cycle `idProc`=0, `carrega_pc` never pulses, all user slots invalid.

Source files
------------

// File: rtl/escalonador_rr_if.sv
// Bus between the instruction counter / SO side (master) and the round-robin
// context-switch engine (slave).
interface escalonador_rr_if;
  // Requests are level-sampled at posedge and acted on only while the engine is
  // idle in EXEC (ocupado=0); a request seen while ocupado=1 is dropped, so the
  // requester keeps it asserted until pausa_PC returns to 1.
  logic        swap_SO;
  logic [31:0] ultimo_pc;
  logic        finalizar;
  logic        despachar;
  logic        criar;
  logic [4:0]  criar_id;
  logic [31:0] criar_pc;
  logic [4:0]  idProc;
  logic [31:0] pc_carga;
  logic        carrega_pc;
  logic        pausa_PC;
  logic        ocupado;

  modport master (
    output swap_SO, ultimo_pc, finalizar, despachar, criar, criar_id, criar_pc,
    input  idProc, pc_carga, carrega_pc, pausa_PC, ocupado
  );

  modport slave (
    input  swap_SO, ultimo_pc, finalizar, despachar, criar, criar_id, criar_pc,
    output idProc, pc_carga, carrega_pc, pausa_PC, ocupado
  );
endinterface

// File: rtl/escalonador_rr.sv
// Round-robin context-switch engine: saves the preempted PC, picks the next
// valid user process and strobes its PC into the program counter loader.
module escalonador_rr #(
    parameter int          NUM_PROC = 8,
    parameter logic [31:0] SO_PC    = 32'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    escalonador_rr_if.slave   bus,
    output logic [1:0]        estado
);

    localparam int          IW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1;
    localparam logic [5:0]  NP = 6'(NUM_PROC);
    localparam logic [5:0]  NU = 6'(NUM_PROC - 1);

    typedef enum logic [1:0] {
        EXEC     = 2'd0,
        SALVA    = 2'd1,
        BUSCA    = 2'd2,
        DESPACHA = 2'd3
    } estado_t;

    estado_t             state_q, state_d;
    logic [31:0]         pc_tab [NUM_PROC];
    logic [NUM_PROC-1:0] valid;
    logic [4:0]          rr_ptr;
    logic [4:0]          id_proc;
    logic [31:0]         pc_carga_q;
    logic                carrega_q;
    logic                pausa_q;
    logic                ocupado_c;

    logic                run_user;
    logic                fin_ok, swap_ok, desp_ok, criar_ok;
    logic [IW-1:0]       id_idx, criar_idx, sel_idx;
    logic [4:0]          sel;
    logic                found;
    logic [5:0]          cand;

    assign run_user  = (id_proc != 5'd0);
    assign fin_ok    = (state_q == EXEC) && bus.finalizar && run_user;
    assign swap_ok   = (state_q == EXEC) && bus.swap_SO   && run_user;
    assign desp_ok   = (state_q == EXEC) && bus.despachar && !run_user;
    assign criar_ok  = bus.criar && (bus.criar_id != 5'd0) && ({1'b0, bus.criar_id} < NP);
    assign id_idx    = id_proc[IW-1:0];
    assign criar_idx = bus.criar_id[IW-1:0];
    assign sel_idx   = sel[IW-1:0];

    // Scan rr_ptr+1 .. NUM_PROC-1 then 1 .. rr_ptr, so the preempted process comes last.
    always_comb begin
        sel   = 5'd0;
        found = 1'b0;
        cand  = 6'd0;
        for (int k = 1; k < NUM_PROC; k++) begin
            cand = {1'b0, rr_ptr} + 6'(k);
            if (cand > NU) cand = cand - NU;
            if (!found && valid[cand[IW-1:0]]) begin
                sel   = cand[4:0];
                found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EXEC;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            EXEC: begin
                if (fin_ok)       state_d = BUSCA;
                else if (swap_ok) state_d = SALVA;
                else if (desp_ok) state_d = BUSCA;
            end
            SALVA:    state_d = BUSCA;
            BUSCA:    state_d = DESPACHA;
            DESPACHA: state_d = EXEC;
            default:  state_d = EXEC;
        endcase
    end

    // Output logic
    always_comb begin
        ocupado_c = (state_q != EXEC);
        estado    = state_q;
    end

    // Only slot 0 has a defined reset value; user slots are written by criar/SALVA.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_tab[0] <= SO_PC;
        end else begin
            if (state_q == SALVA && run_user) pc_tab[id_idx] <= bus.ultimo_pc;
            if (criar_ok)                     pc_tab[criar_idx] <= bus.criar_pc;
        end
    end

    // criar is applied after the finalizar clear so it wins on the same slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= {{(NUM_PROC-1){1'b0}}, 1'b1};
        end else begin
            if (fin_ok)   valid[id_idx]    <= 1'b0;
            if (criar_ok) valid[criar_idx] <= 1'b1;
            valid[0] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_proc    <= 5'd0;
            pc_carga_q <= 32'd0;
            carrega_q  <= 1'b0;
            pausa_q    <= 1'b1;
            rr_ptr     <= 5'd0;
        end else begin
            case (state_q)
                EXEC: begin
                    if (state_d != EXEC) pausa_q <= 1'b0;
                end
                BUSCA: begin
                    id_proc    <= sel;
                    pc_carga_q <= pc_tab[sel_idx];
                    carrega_q  <= 1'b1;
                    if (sel != 5'd0) rr_ptr <= sel;
                end
                DESPACHA: begin
                    carrega_q <= 1'b0;
                    pausa_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.idProc     = id_proc;
    assign bus.pc_carga   = pc_carga_q;
    assign bus.carrega_pc = carrega_q;
    assign bus.pausa_PC   = pausa_q;
    assign bus.ocupado    = ocupado_c;

endmodule

// File: tb/tb_escalonador_rr.sv
// Directed bench for escalonador_rr: dispatch, preemption, termination,
// wrap-around, ignored requests, out-of-range criar and reset mid-switch.
module tb_escalonador_rr;

  logic       clk;
  logic       rst_n;
  logic [1:0] estado;
  int         checks = 0;
  int         errors = 0;

  escalonador_rr_if bus ();

  escalonador_rr #(.NUM_PROC(8), .SO_PC(32'd0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .estado (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int id, input logic [31:0] pc,
                         input logic ld, input logic pz, input logic oc);
    chk({tag, ".idProc"},     32'(bus.idProc),     32'(id));
    chk({tag, ".pc_carga"},   bus.pc_carga,        pc);
    chk({tag, ".carrega_pc"}, 32'(bus.carrega_pc), 32'(ld));
    chk({tag, ".pausa_PC"},   32'(bus.pausa_PC),   32'(pz));
    chk({tag, ".ocupado"},    32'(bus.ocupado),    32'(oc));
  endtask

  task automatic criar(input logic [4:0] id, input logic [31:0] pc);
    bus.criar = 1'b1; bus.criar_id = id; bus.criar_pc = pc;
    tick();
    bus.criar = 1'b0;
  endtask

  // Preemption of the running user process: SALVA, BUSCA, DESPACHA, EXEC.
  task automatic do_swap(input string tag, input logic [31:0] upc,
                         input int id, input logic [31:0] pc);
    bus.swap_SO = 1'b1; bus.ultimo_pc = upc;
    tick();
    bus.swap_SO = 1'b0;
    chk({tag, ".n_pausa"},  32'(bus.pausa_PC), 32'd0);
    chk({tag, ".n_estado"}, 32'(estado),       32'd1);
    tick();
    chk({tag, ".n1_estado"},  32'(estado),         32'd2);
    chk({tag, ".n1_carrega"}, 32'(bus.carrega_pc), 32'd0);
    chk({tag, ".n1_pausa"},   32'(bus.pausa_PC),   32'd0);
    tick();
    chk_out({tag, ".n2"}, id, pc, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out({tag, ".n3"}, id, pc, 1'b0, 1'b1, 1'b0);
  endtask

  // finalizar / despachar (optionally with swap_SO) going straight to BUSCA.
  task automatic do_req(input string tag, input bit fin, input bit desp, input bit swp,
                        input int id, input logic [31:0] pc);
    bus.finalizar = fin; bus.despachar = desp; bus.swap_SO = swp;
    tick();
    bus.finalizar = 1'b0; bus.despachar = 1'b0; bus.swap_SO = 1'b0;
    chk({tag, ".n_pausa"},   32'(bus.pausa_PC),   32'd0);
    chk({tag, ".n_ocupado"}, 32'(bus.ocupado),    32'd1);
    chk({tag, ".n_carrega"}, 32'(bus.carrega_pc), 32'd0);
    tick();
    chk_out({tag, ".n1"}, id, pc, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out({tag, ".n2"}, id, pc, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.swap_SO = 1'b0; bus.ultimo_pc = 32'd0; bus.finalizar = 1'b0;
    bus.despachar = 1'b0; bus.criar = 1'b0; bus.criar_id = 5'd0; bus.criar_pc = 32'd0;
    tick();
    tick();
    rst_n = 1'b1;
    chk_out("reset", 0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("reset.estado", 32'(estado), 32'd0);

    // First dispatch from the SO
    criar(5'd1, 32'h100);
    criar(5'd2, 32'h200);
    do_req("desp1", 1'b0, 1'b1, 1'b0, 1, 32'h100);

    // Round-robin preemption between 1 and 2, resume PCs saved
    do_swap("swap12", 32'h10F, 2, 32'h200);
    do_swap("swap21", 32'h2AA, 1, 32'h10F);

    // Terminate 1 -> 2 resumes; terminate 2 -> back to SO
    do_req("fin1", 1'b1, 1'b0, 1'b0, 2, 32'h2AA);
    do_req("fin2", 1'b1, 1'b0, 1'b0, 0, 32'h0);

    // Requests that must be ignored while the SO runs
    bus.swap_SO = 1'b1; bus.finalizar = 1'b1; bus.ultimo_pc = 32'h777;
    tick();
    chk_out("ign_a", 0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("ign_b", 0, 32'h0, 1'b0, 1'b1, 1'b0);
    bus.swap_SO = 1'b0; bus.finalizar = 1'b0;

    // Out-of-range criar ids leave the table alone
    criar(5'd0, 32'hDEAD);
    criar(5'd9, 32'hBEEF);
    do_req("desp_none", 1'b0, 1'b1, 1'b0, 0, 32'h0);

    // Wrap-around with slots 1, 3, 5
    criar(5'd1, 32'h111);
    criar(5'd3, 32'h333);
    criar(5'd5, 32'h555);
    do_req("desp3", 1'b0, 1'b1, 1'b0, 3, 32'h333);
    do_swap("swap35", 32'h334, 5, 32'h555);
    do_swap("swap51", 32'h556, 1, 32'h111);
    do_swap("swap13", 32'h112, 3, 32'h334);

    // finalizar outranks swap_SO: no save, slot 3 released
    do_req("fin_swap", 1'b1, 1'b0, 1'b1, 5, 32'h556);

    // Reset while in SALVA aborts the switch
    bus.swap_SO = 1'b1; bus.ultimo_pc = 32'h999;
    tick();
    bus.swap_SO = 1'b0;
    chk("rst_mid.estado", 32'(estado), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_out("rst_mid", 0, 32'h0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("rst_mid.no_load", 32'(bus.carrega_pc), 32'd0);
    chk("rst_mid.estado2", 32'(estado), 32'd0);
    do_req("desp_after_rst", 1'b0, 1'b1, 1'b0, 0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
